// File: rtl/pi_code_ctrl.sv
// CDR phase-interpolator loop filter: majority-votes bang-bang PD samples per window,
// runs a proportional + integral path and steps the wrap-around PI phase code.
module pi_code_ctrl #(
    parameter int CODE_MAX = 360,
    parameter int VOTE_LEN = 8,
    parameter int VOTE_TH  = 2,
    parameter int KP_STEP  = 1,
    parameter int FREQ_W   = 12,
    parameter int KI_SHIFT = 4,
    parameter int MAX_STEP = 45,
    parameter int LOCK_WIN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pd_valid,
    input  logic       up,
    input  logic       dn,
    input  logic       freeze,
    input  logic       load,
    input  logic [8:0] load_code,
    output logic [8:0] code,
    output logic       code_valid,
    output logic       locked
);

    localparam int VW = $clog2(VOTE_LEN + 1) + 1;
    localparam int SW = (VOTE_LEN > 1) ? $clog2(VOTE_LEN) : 1;
    localparam int LW = $clog2(LOCK_WIN + 1);
    localparam int AW = FREQ_W + 4;

    localparam logic signed [FREQ_W-1:0] FREQ_ONE = FREQ_W'(1);
    localparam logic signed [FREQ_W-1:0] FREQ_SAT = FREQ_W'((2 ** (FREQ_W - 1)) - 1);
    localparam logic signed [AW-1:0]     STEP_LIM = AW'(MAX_STEP);
    localparam logic signed [AW-1:0]     CODE_LIM = AW'(CODE_MAX);
    localparam logic signed [AW-1:0]     KP_W     = AW'(KP_STEP);
    localparam logic [SW-1:0]            LAST_CNT = SW'(VOTE_LEN - 1);
    localparam logic [LW-1:0]            LOCK_MAX = LW'(LOCK_WIN);

    logic signed [VW-1:0]     vote_acc;
    logic [SW-1:0]            sample_cnt;
    logic signed [FREQ_W-1:0] freq_acc;
    logic [LW-1:0]            lock_cnt;
    logic signed [1:0]        prev_dec;
    logic                     pend_valid;
    logic signed [1:0]        pend_dec;

    logic signed [1:0]        sample_vote;
    logic signed [VW-1:0]     vote_next;
    logic                     window_close;
    logic signed [1:0]        dec;
    logic signed [FREQ_W-1:0] freq_next;
    logic [LW-1:0]            lock_next;
    logic signed [AW-1:0]     step_raw;
    logic signed [AW-1:0]     step;
    logic signed [AW-1:0]     code_sum;
    logic signed [AW-1:0]     code_wrap;
    logic [8:0]               load_wrap;

    // Window vote, decision and the integral / lock updates taken at window close.
    always_comb begin
        sample_vote = 2'sb00;
        if (up && !dn)
            sample_vote = 2'sb01;
        else if (dn && !up)
            sample_vote = 2'sb11;
        vote_next    = vote_acc + VW'(sample_vote);
        window_close = pd_valid && !freeze && (sample_cnt == LAST_CNT);

        dec = 2'sb00;
        if (vote_next >= VOTE_TH)
            dec = 2'sb01;
        else if (vote_next <= -VOTE_TH)
            dec = 2'sb11;

        freq_next = freq_acc;
        if (dec == 2'sb01 && freq_acc != FREQ_SAT)
            freq_next = freq_acc + FREQ_ONE;
        else if (dec == 2'sb11 && freq_acc != -FREQ_SAT)
            freq_next = freq_acc - FREQ_ONE;

        lock_next = lock_cnt;
        if (dec != 2'sb00 && dec == prev_dec)
            lock_next = '0;
        else if (lock_cnt != LOCK_MAX)
            lock_next = lock_cnt + LW'(1);
    end

    // Step from the pending decision, using the already-updated integrator.
    always_comb begin
        step_raw = AW'(pend_dec) * KP_W + AW'(freq_acc >>> KI_SHIFT);
        step     = step_raw;
        if (step_raw > STEP_LIM)
            step = STEP_LIM;
        else if (step_raw < -STEP_LIM)
            step = -STEP_LIM;

        code_sum  = AW'($signed({1'b0, code})) + step;
        code_wrap = code_sum;
        if (code_sum >= CODE_LIM)
            code_wrap = code_sum - CODE_LIM;
        else if (code_sum[AW-1])
            code_wrap = code_sum + CODE_LIM;

        load_wrap = load_code;
        if (load_code >= 9'(CODE_MAX))
            load_wrap = load_code - 9'(CODE_MAX);
    end

    // Load beats freeze, which beats normal voting; freeze also drops any pending step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code       <= '0;
            code_valid <= 1'b0;
            locked     <= 1'b0;
            vote_acc   <= '0;
            sample_cnt <= '0;
            freq_acc   <= '0;
            lock_cnt   <= '0;
            prev_dec   <= 2'sb00;
            pend_valid <= 1'b0;
            pend_dec   <= 2'sb00;
        end else begin
            code_valid <= 1'b0;
            if (load) begin
                code       <= load_wrap;
                code_valid <= 1'b1;
                locked     <= 1'b0;
                vote_acc   <= '0;
                sample_cnt <= '0;
                freq_acc   <= '0;
                lock_cnt   <= '0;
                prev_dec   <= 2'sb00;
                pend_valid <= 1'b0;
            end else if (freeze) begin
                pend_valid <= 1'b0;
            end else begin
                pend_valid <= 1'b0;
                if (pend_valid && step != '0) begin
                    code       <= code_wrap[8:0];
                    code_valid <= 1'b1;
                end
                if (window_close) begin
                    vote_acc   <= '0;
                    sample_cnt <= '0;
                    freq_acc   <= freq_next;
                    prev_dec   <= dec;
                    lock_cnt   <= lock_next;
                    locked     <= (lock_next == LOCK_MAX);
                    pend_valid <= 1'b1;
                    pend_dec   <= dec;
                end else if (pd_valid) begin
                    vote_acc   <= vote_next;
                    sample_cnt <= sample_cnt + SW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pi_code_ctrl.sv
// Self-checking bench for pi_code_ctrl: two instances (KI_SHIFT 4 and 0) against an
// integer reference model, plus table vectors and hand-derived corner sequences.
module tb_pi_code_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pd_valid, up, dn, freeze, load;
    logic [8:0] load_code;
    logic [8:0] code_a, code_b;
    logic       cv_a, cv_b, lk_a, lk_b;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    pi_code_ctrl dut_a (
        .clk(clk), .rst(rst), .pd_valid(pd_valid), .up(up), .dn(dn), .freeze(freeze),
        .load(load), .load_code(load_code), .code(code_a), .code_valid(cv_a), .locked(lk_a)
    );

    pi_code_ctrl #(.KI_SHIFT(0)) dut_b (
        .clk(clk), .rst(rst), .pd_valid(pd_valid), .up(up), .dn(dn), .freeze(freeze),
        .load(load), .load_code(load_code), .code(code_b), .code_valid(cv_b), .locked(lk_b)
    );

    typedef struct {
        int code;
        int freq;
        int votes;
        int cnt;
        int lockc;
        int prev;
        bit pend;
        int pdec;
        bit cv;
        bit lk;
    } model_t;

    model_t mdl [2];

    function automatic model_t model_reset();
        model_t s;
        s = '{0, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0};
        return s;
    endfunction

    function automatic int floor_pow2(int x, int k);
        int p;
        p = 1 << k;
        if (x >= 0)
            return x / p;
        return -((-x + p - 1) / p);
    endfunction

    // One clock of the loop in plain integer arithmetic.
    function automatic model_t model_next(model_t s, int ki, bit pv, bit u, bit d,
                                          bit frz, bit ld, int lc);
        model_t n;
        int v, dc, st;
        n = s;
        n.cv = 1'b0;
        if (ld) begin
            n = model_reset();
            n.code = (lc < 360) ? lc : lc - 360;
            n.cv = 1'b1;
            return n;
        end
        if (frz) begin
            n.pend = 1'b0;
            return n;
        end
        n.pend = 1'b0;
        if (s.pend) begin
            st = s.pdec + floor_pow2(s.freq, ki);
            if (st > 45) st = 45;
            if (st < -45) st = -45;
            if (st != 0) begin
                n.code = ((s.code + st) % 360 + 360) % 360;
                n.cv = 1'b1;
            end
        end
        if (pv) begin
            v = s.votes + ((u && !d) ? 1 : 0) - ((d && !u) ? 1 : 0);
            if (s.cnt == 7) begin
                dc = (v >= 2) ? 1 : ((v <= -2) ? -1 : 0);
                n.freq = s.freq + dc;
                if (n.freq > 2047) n.freq = 2047;
                if (n.freq < -2047) n.freq = -2047;
                if (dc != 0 && dc == s.prev)
                    n.lockc = 0;
                else if (s.lockc < 16)
                    n.lockc = s.lockc + 1;
                n.prev  = dc;
                n.lk    = (n.lockc == 16);
                n.pend  = 1'b1;
                n.pdec  = dc;
                n.votes = 0;
                n.cnt   = 0;
            end else begin
                n.votes = v;
                n.cnt   = s.cnt + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl[0] <= model_reset();
            mdl[1] <= model_reset();
        end else begin
            mdl[0] <= model_next(mdl[0], 4, pd_valid, up, dn, freeze, load, int'(load_code));
            mdl[1] <= model_next(mdl[1], 0, pd_valid, up, dn, freeze, load, int'(load_code));
        end
    end

    task automatic checkValue(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("model code_a", int'(code_a), mdl[0].code);
        checkValue("model cv_a", int'(cv_a), int'(mdl[0].cv));
        checkValue("model locked_a", int'(lk_a), int'(mdl[0].lk));
        checkValue("model code_b", int'(code_b), mdl[1].code);
        checkValue("model cv_b", int'(cv_b), int'(mdl[1].cv));
        checkValue("model locked_b", int'(lk_b), int'(mdl[1].lk));
    endtask

    task automatic applyStimulus(input bit pv, input bit u, input bit d, input bit frz,
                                 input bit ld, input int lc);
        pd_valid  = pv;
        up        = u;
        dn        = d;
        freeze    = frz;
        load      = ld;
        load_code = 9'(lc);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic runWindow(input bit [7:0] um, input bit [7:0] dm);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, um[i], dm[i], 1'b0, 1'b0, 0);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic loadCode(input int lc);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, lc);
    endtask

    typedef struct {
        bit       ld;
        int       lc;
        bit [7:0] upm;
        bit [7:0] dnm;
        int       exp_code;
        bit       exp_cv;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int bias, r;
        bit pv, u, d, frz, ld;

        tbl[0]  = '{1'b0, 0,   8'hFF,        8'h00,        1,   1'b1};
        tbl[1]  = '{1'b1, 359, 8'h00,        8'h00,        359, 1'b1};
        tbl[2]  = '{1'b0, 0,   8'hFF,        8'h00,        0,   1'b1};
        tbl[3]  = '{1'b1, 1,   8'h00,        8'h00,        1,   1'b1};
        tbl[4]  = '{1'b0, 0,   8'h00,        8'hFF,        359, 1'b1};
        tbl[5]  = '{1'b1, 0,   8'h00,        8'h00,        0,   1'b1};
        tbl[6]  = '{1'b0, 0,   8'b0001_1111, 8'b1110_0000, 1,   1'b1};
        tbl[7]  = '{1'b0, 0,   8'b1000_1111, 8'b1111_0000, 1,   1'b0};
        tbl[8]  = '{1'b1, 400, 8'h00,        8'h00,        40,  1'b1};
        tbl[9]  = '{1'b1, 511, 8'h00,        8'h00,        151, 1'b1};
        tbl[10] = '{1'b1, 360, 8'h00,        8'h00,        0,   1'b1};

        rst = 1'b1;
        pd_valid = 1'b0; up = 1'b0; dn = 1'b0; freeze = 1'b0; load = 1'b0; load_code = '0;
        #12;
        checkValue("reset code", int'(code_a), 0);
        checkValue("reset code_valid", int'(cv_a), 0);
        checkValue("reset locked", int'(lk_a), 0);
        checkOutput();
        rst = 1'b0;

        for (int k = 0; k < 11; k++) begin
            if (tbl[k].ld) begin
                loadCode(tbl[k].lc);
            end else begin
                runWindow(tbl[k].upm, tbl[k].dnm);
                idleCycle();
            end
            checkValue($sformatf("table%0d code", k), int'(code_a), tbl[k].exp_code);
            checkValue($sformatf("table%0d code_valid", k), int'(cv_a), int'(tbl[k].exp_cv));
        end

        // 50 up windows: integral term grows, KI_SHIFT=0 instance hits the step clamp.
        loadCode(0);
        for (int w = 0; w < 50; w++)
            runWindow(8'hFF, 8'h00);
        idleCycle();
        checkValue("freq ramp code ki4", int'(code_a), 107);
        checkValue("freq ramp code ki0 clamp", int'(code_b), 224);

        loadCode(0);
        for (int w = 1; w <= 16; w++) begin
            if (w % 2 == 1)
                runWindow(8'hFF, 8'h00);
            else
                runWindow(8'h00, 8'hFF);
            if (w == 15) checkValue("locked after 15 dither", int'(lk_a), 0);
            if (w == 16) checkValue("locked after 16 dither", int'(lk_a), 1);
        end
        runWindow(8'hFF, 8'h00);
        checkValue("locked after flip", int'(lk_a), 1);
        runWindow(8'hFF, 8'h00);
        checkValue("locked after repeat", int'(lk_a), 0);
        checkValue("locked_b after repeat", int'(lk_b), 0);

        loadCode(0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 20; i++)
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idleCycle();
        checkValue("freeze resume code", int'(code_a), 1);
        checkValue("freeze resume code_valid", int'(cv_a), 1);

        runWindow(8'hFF, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        checkValue("freeze discard code", int'(code_a), 1);
        checkValue("freeze discard code_valid", int'(cv_a), 0);
        idleCycle();
        checkValue("freeze discard later", int'(code_a), 1);

        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 100);
        checkValue("load at close code", int'(code_a), 100);
        checkValue("load at close code_valid", int'(cv_a), 1);
        idleCycle();
        checkValue("load at close no step", int'(code_a), 100);
        checkValue("load at close no pulse", int'(cv_a), 0);

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        checkValue("mid reset code", int'(code_a), 0);
        checkValue("mid reset locked", int'(lk_a), 0);
        checkOutput();
        #1 rst = 1'b0;
        runWindow(8'hFF, 8'h00);
        idleCycle();
        checkValue("post reset window code", int'(code_a), 1);

        for (int c = 0; c < 2000; c++) begin
            if (c % 64 == 0) bias = int'($urandom_range(0, 2));
            r   = int'($urandom_range(0, 9));
            pv  = ($urandom_range(0, 3) != 0);
            u   = (bias == 0) ? (r < 7) : ((bias == 1) ? (r >= 7) : (r < 5));
            d   = (bias == 0) ? (r >= 5) : ((bias == 1) ? (r < 5) : (r >= 4));
            frz = ($urandom_range(0, 31) == 0);
            ld  = ($urandom_range(0, 199) == 0);
            applyStimulus(pv, u, d, frz, ld, int'($urandom_range(0, 511)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
